// File: rtl/hack_cpu_ctrl_if.sv
// Bus between the Hack CPU controller and its ROM, data RAM and external ALU.
// Handshake: the controller raises instr_req (ready) in FETCH. The environment
// raises instr_valid with the word. The word transfers on a clock edge where both are high.
interface hack_cpu_ctrl_if;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_req;
  logic [14:0] pc;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [5:0]  operation;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] out;
  logic        zr;
  logic        ng;
  logic [15:0] areg;
  logic [15:0] dreg;
  logic        halted;
  logic [1:0]  fsm_state;

  modport master (
    input  instruction, instr_valid, inM, out, zr, ng,
    output instr_req, pc, outM, writeM, addressM, operation, x, y,
           areg, dreg, halted, fsm_state
  );

  modport slave (
    output instruction, instr_valid, inM, out, zr, ng,
    input  instr_req, pc, outM, writeM, addressM, operation, x, y,
           areg, dreg, halted, fsm_state
  );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control path: two-cycle fetch/execute over an external ALU.
// A self-loop jump parks the controller in HALT until reset.
module hack_cpu_ctrl (
  input  logic             clk,
  input  logic             reset,
  hack_cpu_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [14:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;

  logic [14:0] pc_inc;
  logic        jump;

  assign pc_inc = pc_q + 15'd1;
  assign jump   = ir_q[15] & ((ir_q[2] & bus.ng) | (ir_q[1] & bus.zr) |
                              (ir_q[0] & ~bus.ng & ~bus.zr));

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    d_d      = d_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    req_d    = req_q;
    wr_d     = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (req_q && bus.instr_valid) begin
          ir_d    = bus.instruction;
          state_d = EXEC;
          req_d   = 1'b0;
          // writeM is registered so it is high for exactly the EXEC cycle
          wr_d    = bus.instruction[15] & bus.instruction[3];
        end else begin
          req_d   = 1'b1;
        end
      end
      EXEC: begin
        if (!ir_q[15]) begin
          a_d     = ir_q;
          pc_d    = pc_inc;
          state_d = FETCH;
          req_d   = 1'b1;
        end else begin
          if (ir_q[5]) a_d = bus.out;
          if (ir_q[4]) d_d = bus.out;
          // Jump target and self-loop test use A from before this cycle's write
          pc_d = jump ? a_q[14:0] : pc_inc;
          if (jump && (a_q[14:0] == pc_q)) begin
            state_d  = HALT;
            halted_d = 1'b1;
            req_d    = 1'b0;
          end else begin
            state_d  = FETCH;
            req_d    = 1'b1;
          end
        end
      end
      HALT: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      ir_q     <= 16'd0;
      a_q      <= 16'd0;
      d_q      <= 16'd0;
      pc_q     <= 15'd0;
      halted_q <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      d_q      <= d_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
    end
  end

  assign bus.instr_req = req_q;
  assign bus.pc        = pc_q;
  assign bus.outM      = bus.out;
  assign bus.writeM    = wr_q;
  assign bus.addressM  = a_q[14:0];
  assign bus.operation = ir_q[11:6];
  assign bus.x         = d_q;
  assign bus.y         = ir_q[12] ? bus.inM : a_q;
  assign bus.areg      = a_q;
  assign bus.dreg      = d_q;
  assign bus.halted    = halted_q;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: ROM, RAM and Hack ALU environment plus an
// instruction-level reference model of the Hack machine.
module tb_hack_cpu_ctrl;

  logic clk;
  logic reset;
  hack_cpu_ctrl_if bus();

  hack_cpu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment ----------------
  logic [15:0] env_ram [0:32767];
  logic [15:0] m_ram   [0:32767];
  logic [15:0] rom     [int];

  function automatic logic [15:0] hack_alu(input logic [5:0] op,
                                           input logic [15:0] xv,
                                           input logic [15:0] yv);
    logic [15:0] a, b, r;
    a = op[5] ? 16'd0 : xv;
    if (op[4]) a = ~a;
    b = op[3] ? 16'd0 : yv;
    if (op[2]) b = ~b;
    r = op[1] ? (a + b) : (a & b);
    if (op[0]) r = ~r;
    return r;
  endfunction

  assign bus.out = hack_alu(bus.operation, bus.x, bus.y);
  assign bus.zr  = (bus.out == 16'd0);
  assign bus.ng  = bus.out[15];
  assign bus.inM = env_ram[bus.addressM];

  // ---------------- reference model state ----------------
  logic [15:0] m_a, m_d;
  int          m_pc;
  bit          m_halt;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    if ($urandom_range(1, 0) == 0) begin
      w = {1'b0, ($urandom_range(3, 0) == 0) ? 15'($urandom) : 15'($urandom_range(63, 0))};
    end else begin
      w = 16'($urandom);
      w[15] = 1'b1;
      if ($urandom_range(5, 0) != 0) w[2:0] = 3'b000;
    end
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    m_pc = 0; m_a = 16'd0; m_d = 16'd0; m_halt = 1'b0;
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    #1;
    check("rst_req",    bus.instr_req, 0);
    check("rst_wm",     bus.writeM,    0);
    check("rst_pc",     bus.pc,        0);
    check("rst_a",      bus.areg,      0);
    check("rst_d",      bus.dreg,      0);
    check("rst_halted", bus.halted,    0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req", bus.instr_req, 1);
    check("post_rst_pc",  bus.pc,        0);
  endtask

  // One instruction: optional fetch stall, fetch, EXEC checks, result checks.
  task automatic exec_one(input int delay);
    logic [15:0] ir, m, yv, r, old_a;
    bit          exp_we, take, pend;
    logic [14:0] exp_addr, pend_addr;
    logic [15:0] exp_val, pend_val;
    int          p;
    for (int i = 0; i < delay; i++) begin
      check("wait_req", bus.instr_req, 1);
      check("wait_pc",  bus.pc, m_pc);
      @(negedge clk);
    end
    check("fetch_req", bus.instr_req, 1);
    check("fetch_pc",  bus.pc, m_pc);
    p = m_pc;
    if (!rom.exists(p)) rom[p] = rand_instr();
    ir = rom[p];
    bus.instruction = ir;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instruction = 16'($urandom);

    exp_we = 1'b0; exp_addr = 15'd0; exp_val = 16'd0;
    if (!ir[15]) begin
      m_a  = ir;
      m_pc = (m_pc + 1) & 32'h7FFF;
    end else begin
      old_a = m_a;
      m    = m_ram[old_a[14:0]];
      yv   = ir[12] ? m : old_a;
      r    = hack_alu(ir[11:6], m_d, yv);
      take = (ir[2] && $signed(r) < 0) || (ir[1] && r == 16'd0) || (ir[0] && $signed(r) > 0);
      if (ir[3]) begin
        exp_we = 1'b1; exp_addr = old_a[14:0]; exp_val = r;
        m_ram[old_a[14:0]] = r;
      end
      if (ir[5]) m_a = r;
      if (ir[4]) m_d = r;
      if (take) begin
        if (int'(old_a[14:0]) == m_pc) m_halt = 1'b1;
        m_pc = int'(old_a[14:0]);
      end else begin
        m_pc = (m_pc + 1) & 32'h7FFF;
      end
    end

    check("exec_req", bus.instr_req, 0);
    check("exec_wm",  bus.writeM, exp_we);
    if (exp_we) begin
      check("exec_addr", bus.addressM, exp_addr);
      check("exec_outm", bus.outM, exp_val);
    end
    pend = bus.writeM; pend_addr = bus.addressM; pend_val = bus.outM;
    @(negedge clk);
    if (pend) env_ram[pend_addr] = pend_val;
    check("res_pc",     bus.pc, m_pc);
    check("res_a",      bus.areg, m_a);
    check("res_d",      bus.dreg, m_d);
    check("res_halted", bus.halted, m_halt);
  endtask

  task automatic run_prog(input int n, input int delay);
    for (int i = 0; i < n && !m_halt; i++)
      exec_one(delay < 0 ? int'($urandom_range(3, 0)) : delay);
    if (m_halt) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("halt_req", bus.instr_req, 0);
        check("halt_flag", bus.halted, 1);
        check("halt_pc", bus.pc, m_pc);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instruction = 16'd0;
    for (int i = 0; i < 32768; i++) begin
      env_ram[i] = 16'd0;
      m_ram[i]   = 16'd0;
    end
    @(negedge clk);
    apply_reset();

    // fetch stall then A-instruction
    rom.delete(); rom[0] = 16'h0005;
    exec_one(3);
    check("a_instr_areg", bus.areg, 16'h0005);
    check("a_instr_pc",   bus.pc,   1);

    // memory write via M=D
    apply_reset(); rom.delete();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0007; rom[3] = 16'hE308;
    run_prog(4, -1);
    check("m_eq_d_dreg", bus.dreg, 16'h0005);

    // conditional jump taken (D=0) then not taken (D=1)
    apply_reset(); rom.delete();
    rom[0] = 16'hEA90; rom[1] = 16'h0010; rom[2] = 16'hE302;
    rom[16] = 16'hEFD0; rom[17] = 16'h0010; rom[18] = 16'hE302;
    run_prog(3, 0);
    check("jeq_taken_pc", bus.pc, 16'h0010);
    run_prog(3, 1);
    check("jeq_not_taken_pc", bus.pc, 16'h0013);

    // simultaneous A write, memory write and jump
    apply_reset(); rom.delete();
    rom[0] = 16'h0020; rom[1] = 16'hEDEF;
    run_prog(2, 0);
    check("simul_pc",   bus.pc,   16'h0020);
    check("simul_areg", bus.areg, 16'h0021);

    // self-loop halt
    apply_reset(); rom.delete();
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h0003; rom[3] = 16'hEA87;
    run_prog(10, -1);
    check("halt_set", bus.halted, 1);

    // pc wrap at 0x7FFF
    apply_reset(); rom.delete();
    rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[32767] = 16'h0001;
    run_prog(3, 0);
    check("wrap_pc", bus.pc, 0);

    // reset during EXEC of M=D
    apply_reset(); rom.delete();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0007; rom[3] = 16'hE308;
    run_prog(3, 0);
    bus.instruction = rom[3];
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("mid_exec_wm", bus.writeM, 1);
    apply_reset();

    // randomized programs
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      rom.delete();
      run_prog(150, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
